// File: rtl/cache_arbiter_if.sv
// Cache-to-pmem arbiter bus bundle: I-cache port, D-cache port and physical memory port.
// slave = arbiter side, master = caches + physical memory side.
interface cache_arbiter_if #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned BLOCK_WIDTH = 128
);
    logic                   i_pmem_read;
    logic [ADDR_WIDTH-1:0]  i_pmem_address;
    logic                   i_pmem_resp;
    logic [BLOCK_WIDTH-1:0] i_pmem_rdata;

    logic                   d_pmem_read;
    logic                   d_pmem_write;
    logic [ADDR_WIDTH-1:0]  d_pmem_address;
    logic [BLOCK_WIDTH-1:0] d_pmem_wdata;
    logic                   d_pmem_resp;
    logic [BLOCK_WIDTH-1:0] d_pmem_rdata;

    logic                   pmem_read;
    logic                   pmem_write;
    logic [ADDR_WIDTH-1:0]  pmem_address;
    logic [BLOCK_WIDTH-1:0] pmem_wdata;
    logic                   pmem_resp;
    logic [BLOCK_WIDTH-1:0] pmem_rdata;

    modport slave (
        input  i_pmem_read, i_pmem_address,
        output i_pmem_resp, i_pmem_rdata,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output d_pmem_resp, d_pmem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata
    );

    modport master (
        output i_pmem_read, i_pmem_address,
        input  i_pmem_resp, i_pmem_rdata,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  d_pmem_resp, d_pmem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// Serialises I-cache and D-cache block requests onto one pmem port; all outputs registered.
// Optional ARB_ROUND_ROBIN_EN: contention resolved by a flipping priority pointer instead of fixed D-over-I.
module cache_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned BLOCK_WIDTH = 128
) (
    input  logic            clk,
    input  logic            reset,
    cache_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT_I,
        S_GRANT_D,
        S_DONE_I,
        S_DONE_D
    } state_t;

    state_t                 r_state,        w_state;
    logic                   r_pmem_read,    w_pmem_read;
    logic                   r_pmem_write,   w_pmem_write;
    logic [ADDR_WIDTH-1:0]  r_pmem_address, w_pmem_address;
    logic [BLOCK_WIDTH-1:0] r_pmem_wdata,   w_pmem_wdata;
    logic                   r_i_resp,       w_i_resp;
    logic                   r_d_resp,       w_d_resp;
    logic [BLOCK_WIDTH-1:0] r_i_rdata,      w_i_rdata;
    logic [BLOCK_WIDTH-1:0] r_d_rdata,      w_d_rdata;

    logic w_i_req;
    logic w_d_req;
    logic w_contend;
    logic w_pick_d;

    assign w_i_req   = bus.i_pmem_read;
    assign w_d_req   = bus.d_pmem_read | bus.d_pmem_write;
    assign w_contend = w_i_req & w_d_req;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = D-cache holds priority on the next contended grant
    logic r_prio_d, w_prio_d;
    assign w_pick_d = w_d_req & (~w_i_req | r_prio_d);
`else
    assign w_pick_d = w_d_req;
`endif

    // Next-state and next-output decode
    always_comb begin
        w_state        = r_state;
        w_pmem_read    = r_pmem_read;
        w_pmem_write   = r_pmem_write;
        w_pmem_address = r_pmem_address;
        w_pmem_wdata   = r_pmem_wdata;
        w_i_resp       = 1'b0;
        w_d_resp       = 1'b0;
        w_i_rdata      = r_i_rdata;
        w_d_rdata      = r_d_rdata;
`ifdef ARB_ROUND_ROBIN_EN
        w_prio_d       = r_prio_d;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_pick_d) begin
                    w_state        = S_GRANT_D;
                    w_pmem_address = bus.d_pmem_address;
                    w_pmem_wdata   = bus.d_pmem_wdata;
                    // write wins if a cache ever raises both strobes
                    w_pmem_write   = bus.d_pmem_write;
                    w_pmem_read    = ~bus.d_pmem_write;
                end else if (w_i_req) begin
                    w_state        = S_GRANT_I;
                    w_pmem_address = bus.i_pmem_address;
                    w_pmem_wdata   = '0;
                    w_pmem_write   = 1'b0;
                    w_pmem_read    = 1'b1;
                end
`ifdef ARB_ROUND_ROBIN_EN
                if (w_contend) begin
                    w_prio_d = ~r_prio_d;
                end
`endif
            end
            S_GRANT_I: begin
                if (bus.pmem_resp) begin
                    w_state      = S_DONE_I;
                    w_pmem_read  = 1'b0;
                    w_pmem_write = 1'b0;
                    w_i_resp     = 1'b1;
                    w_i_rdata    = bus.pmem_rdata;
                end
            end
            S_GRANT_D: begin
                if (bus.pmem_resp) begin
                    w_state      = S_DONE_D;
                    w_pmem_read  = 1'b0;
                    w_pmem_write = 1'b0;
                    w_d_resp     = 1'b1;
                    if (r_pmem_read) begin
                        w_d_rdata = bus.pmem_rdata;
                    end
                end
            end
            S_DONE_I,
            S_DONE_D: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state      = S_IDLE;
                w_pmem_read  = 1'b0;
                w_pmem_write = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_i_resp       <= 1'b0;
            r_d_resp       <= 1'b0;
            r_i_rdata      <= '0;
            r_d_rdata      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_prio_d       <= 1'b1;
`endif
        end else begin
            r_state        <= w_state;
            r_pmem_read    <= w_pmem_read;
            r_pmem_write   <= w_pmem_write;
            r_pmem_address <= w_pmem_address;
            r_pmem_wdata   <= w_pmem_wdata;
            r_i_resp       <= w_i_resp;
            r_d_resp       <= w_d_resp;
            r_i_rdata      <= w_i_rdata;
            r_d_rdata      <= w_d_rdata;
`ifdef ARB_ROUND_ROBIN_EN
            r_prio_d       <= w_prio_d;
`endif
        end
    end

    assign bus.pmem_read    = r_pmem_read;
    assign bus.pmem_write   = r_pmem_write;
    assign bus.pmem_address = r_pmem_address;
    assign bus.pmem_wdata   = r_pmem_wdata;
    assign bus.i_pmem_resp  = r_i_resp;
    assign bus.i_pmem_rdata = r_i_rdata;
    assign bus.d_pmem_resp  = r_d_resp;
    assign bus.d_pmem_rdata = r_d_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed and random cache traffic checked cycle by cycle against a
// transaction-level model of grant order, pmem strobes and returned data.
module tb_cache_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned BW = 128;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_arbiter_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) bus ();

    cache_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // model state: last read data per port and contention pointer (1 = D first)
    logic [BW-1:0] m_i_rdata = '0;
    logic [BW-1:0] m_d_rdata = '0;
    bit            m_prio_d  = 1'b1;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [BW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, ".pmem_read"},  BW'(bus.pmem_read),   '0);
        chk({tag, ".pmem_write"}, BW'(bus.pmem_write),  '0);
        chk({tag, ".i_resp"},     BW'(bus.i_pmem_resp), '0);
        chk({tag, ".d_resp"},     BW'(bus.d_pmem_resp), '0);
        chk({tag, ".i_rdata"},    bus.i_pmem_rdata,     m_i_rdata);
        chk({tag, ".d_rdata"},    bus.d_pmem_rdata,     m_d_rdata);
    endtask

    // Present one request set (called at a negedge) and follow every grant it produces.
    // dop: 0 none, 1 read, 2 write-back. rd_a/rd_b: pmem data for first/second grant.
    task automatic txn(input bit ireq, input logic [AW-1:0] ia, input int dop,
                       input logic [AW-1:0] da, input logic [BW-1:0] dw, input int lat,
                       input logic [BW-1:0] rd_a, input logic [BW-1:0] rd_b, input bit spur);
        bit order_d[2];
        int ng;
        bus.i_pmem_read    = ireq;
        bus.i_pmem_address = ia;
        bus.d_pmem_read    = (dop == 1);
        bus.d_pmem_write   = (dop == 2);
        bus.d_pmem_address = da;
        bus.d_pmem_wdata   = dw;
        bus.pmem_resp      = spur;
        ng = 0;
        if (ireq && dop != 0) begin
`ifdef ARB_ROUND_ROBIN_EN
            order_d[0] = m_prio_d;
            m_prio_d   = !m_prio_d;
`else
            order_d[0] = 1'b1;
`endif
            order_d[1] = !order_d[0];
            ng = 2;
        end else if (dop != 0) begin
            order_d[0] = 1'b1;
            ng = 1;
        end else if (ireq) begin
            order_d[0] = 1'b0;
            ng = 1;
        end
        for (int g = 0; g < ng; g++) begin
            bit            is_d = order_d[g];
            bit            wr   = is_d && (dop == 2);
            logic [AW-1:0] ea   = is_d ? da : ia;
            logic [BW-1:0] rd   = (g == 0) ? rd_a : rd_b;
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                chk("grant.pmem_read",    BW'(bus.pmem_read),    BW'(!wr));
                chk("grant.pmem_write",   BW'(bus.pmem_write),   BW'(wr));
                chk("grant.pmem_address", BW'(bus.pmem_address), BW'(ea));
                if (wr) chk("grant.pmem_wdata", bus.pmem_wdata, dw);
                chk("grant.i_resp", BW'(bus.i_pmem_resp), '0);
                chk("grant.d_resp", BW'(bus.d_pmem_resp), '0);
                bus.pmem_resp  = (c == lat);
                bus.pmem_rdata = (c == lat) ? rd : rand128();
                // requester inputs wander while granted; the latched copy must not follow
                if (c == 1) begin
                    if (is_d) begin
                        bus.d_pmem_address = AW'($urandom);
                        bus.d_pmem_wdata   = rand128();
                    end else begin
                        bus.i_pmem_address = AW'($urandom);
                    end
                end
            end
            @(negedge clk);
            if (!wr) begin
                if (is_d) m_d_rdata = rd;
                else      m_i_rdata = rd;
            end
            chk("done.pmem_read",  BW'(bus.pmem_read),   '0);
            chk("done.pmem_write", BW'(bus.pmem_write),  '0);
            chk("done.i_resp",     BW'(bus.i_pmem_resp), BW'(!is_d));
            chk("done.d_resp",     BW'(bus.d_pmem_resp), BW'(is_d));
            chk("done.i_rdata",    bus.i_pmem_rdata,     m_i_rdata);
            chk("done.d_rdata",    bus.d_pmem_rdata,     m_d_rdata);
            bus.pmem_resp  = spur;
            bus.pmem_rdata = rand128();
            if (is_d) begin
                bus.d_pmem_read  = 1'b0;
                bus.d_pmem_write = 1'b0;
            end else begin
                bus.i_pmem_read = 1'b0;
            end
            @(negedge clk);
            chk_quiet("idle");
        end
    endtask

    initial begin
        bus.i_pmem_read    = 1'b0;
        bus.i_pmem_address = '0;
        bus.d_pmem_read    = 1'b0;
        bus.d_pmem_write   = 1'b0;
        bus.d_pmem_address = '0;
        bus.d_pmem_wdata   = '0;
        bus.pmem_resp      = 1'b0;
        bus.pmem_rdata     = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        chk("reset.pmem_address", BW'(bus.pmem_address), '0);
        chk("reset.pmem_wdata",   bus.pmem_wdata,         '0);
        reset = 1'b0;

        // I-only read, 3-cycle memory
        txn(1'b1, 16'h0040, 0, 16'h0000, '0, 3,
            128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, '0, 1'b0);
        // D write-back leaves d_rdata alone
        txn(1'b0, 16'h0000, 2, 16'h8A00, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 2,
            rand128(), '0, 1'b0);
        // contention twice back-to-back
        txn(1'b1, 16'h0100, 1, 16'h2200, '0, 2, rand128(), rand128(), 1'b0);
        txn(1'b1, 16'h0100, 1, 16'h2200, '0, 3, rand128(), rand128(), 1'b1);

        for (int k = 0; k < 60; k++) begin
            bit ir = 1'($urandom);
            int op = int'($urandom_range(0, 2));
            if (!ir && op == 0) ir = 1'b1;
            txn(ir, AW'($urandom), op, AW'($urandom), rand128(),
                int'($urandom_range(1, 4)), rand128(), rand128(), 1'($urandom));
        end

        // reset in the middle of a D write-back grant
        bus.d_pmem_write   = 1'b1;
        bus.d_pmem_address = 16'h1230;
        bus.d_pmem_wdata   = rand128();
        bus.pmem_resp      = 1'b0;
        @(negedge clk);
        chk("rst_mid.pmem_write",   BW'(bus.pmem_write),   BW'(1));
        chk("rst_mid.pmem_address", BW'(bus.pmem_address), BW'(16'h1230));
        reset            = 1'b1;
        bus.d_pmem_write = 1'b0;
        @(negedge clk);
        m_i_rdata = '0;
        m_d_rdata = '0;
        m_prio_d  = 1'b1;
        chk_quiet("rst_mid");
        chk("rst_mid.pmem_address", BW'(bus.pmem_address), '0);
        reset = 1'b0;

        // pointer back at D after reset
        txn(1'b1, 16'h0500, 1, 16'h0600, '0, 1, rand128(), rand128(), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
